// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit_if
// Purpose  : IF/ID-side request signals and registered ID/EX control bundle.
// Revision : 1.0
// ============================================================================
interface pipelined_control_unit_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               flush;
    logic               stall;
    logic               ex_valid;
    logic [2:0]         ex_alu_op;
    logic               ex_reg_write;
    logic               ex_alu_src;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_mem_to_reg;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_lui;
    logic               ex_auipc;
    logic               ex_illegal;
    logic               ex_muldiv;
    logic [REG_AW-1:0]  ex_rd;
    logic [REG_AW-1:0]  ex_rs1;
    logic [REG_AW-1:0]  ex_rs2;
    logic [2:0]         ex_func3;

    modport master (
        output instr, instr_valid, flush,
        input  stall, ex_valid, ex_alu_op, ex_reg_write, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
               ex_jump, ex_lui, ex_auipc, ex_illegal, ex_muldiv,
               ex_rd, ex_rs1, ex_rs2, ex_func3
    );

    modport slave (
        input  instr, instr_valid, flush,
        output stall, ex_valid, ex_alu_op, ex_reg_write, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
               ex_jump, ex_lui, ex_auipc, ex_illegal, ex_muldiv,
               ex_rd, ex_rs1, ex_rs2, ex_func3
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Purpose  : RV32I decode stage with registered ID/EX bundle, load-use stall
//            and flush bubbles. Define RV32M_MULDIV_EN for mul/div decode and
//            multi-cycle divide stalls.
// Revision : 1.0
// ============================================================================
module pipelined_control_unit #(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    pipelined_control_unit_if.slave bus
);
    localparam logic [0:0] c_RUN     = 1'b0;
    localparam logic [0:0] c_MD_BUSY = 1'b1;
    localparam int         c_CNT_W   = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DIV_CYCLES - 2);

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              jump;
        logic              lui;
        logic              auipc;
        logic              illegal;
        logic              muldiv;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [2:0]        func3;
    } ctl_t;

    ctl_t               r_ex;
    ctl_t               w_dec;
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_use_rs1;
    logic               w_use_rs2;
    logic               w_load_use;
    logic               w_md_start;
    logic [6:0]         w_opcode;
    logic [6:0]         w_func7;

    assign w_opcode = bus.instr[6:0];
    assign w_func7  = bus.instr[31:25];

    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_dec.rd    = bus.instr[7 +: REG_AW];
        w_dec.rs1   = bus.instr[15 +: REG_AW];
        w_dec.rs2   = bus.instr[20 +: REG_AW];
        w_dec.func3 = bus.instr[14:12];
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_dec.alu_op    = 3'b010;
                w_dec.reg_write = 1'b1;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
`ifdef RV32M_MULDIV_EN
                if (w_func7 == 7'b0000001) begin
                    w_dec.alu_op = 3'b110;
                    w_dec.muldiv = 1'b1;
                end
`endif
            end
            7'b0010011: begin
                w_dec.alu_op    = 3'b011;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_use_rs1       = 1'b1;
            end
            7'b0000011: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_use_rs1        = 1'b1;
            end
            7'b0100011: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
            end
            7'b1100011: begin
                w_dec.alu_op = 3'b101;
                w_dec.branch = 1'b1;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
            end
            7'b0110111: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.lui       = 1'b1;
            end
            7'b0010111: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.auipc     = 1'b1;
            end
            7'b1101111: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.jump      = 1'b1;
            end
            7'b1100111: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.jump      = 1'b1;
                w_use_rs1       = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

`ifdef RV32M_MULDIV_EN
    // Only DIV/DIVU/REM/REMU (func3[2]=1) are multi-cycle.
    assign w_md_start = w_dec.muldiv & w_dec.func3[2];
`else
    logic w_unused_func7;
    assign w_unused_func7 = ^w_func7;
    assign w_md_start     = 1'b0;
`endif

    assign w_load_use = r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) & bus.instr_valid &
                        ((w_use_rs1 & (w_dec.rs1 == r_ex.rd)) |
                         (w_use_rs2 & (w_dec.rs2 == r_ex.rd)));

    assign bus.stall = ~bus.flush & ((r_state == c_MD_BUSY) | w_load_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex    <= '0;
            r_state <= c_RUN;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_ex    <= '0;
            r_state <= c_RUN;
            r_cnt   <= '0;
        end else if (r_state == c_MD_BUSY) begin
            // ID/EX keeps the divide while the counter runs down.
            if (r_cnt == '0) begin
                r_state <= c_RUN;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (w_load_use || !bus.instr_valid) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_dec;
            if (w_md_start) begin
                r_state <= c_MD_BUSY;
                r_cnt   <= c_CNT_INIT;
            end
        end
    end

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_alu_op     = r_ex.alu_op;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_alu_src    = r_ex.alu_src;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign bus.ex_branch     = r_ex.branch;
    assign bus.ex_jump       = r_ex.jump;
    assign bus.ex_lui        = r_ex.lui;
    assign bus.ex_auipc      = r_ex.auipc;
    assign bus.ex_illegal    = r_ex.illegal;
    assign bus.ex_muldiv     = r_ex.muldiv;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_rs1        = r_ex.rs1;
    assign bus.ex_rs2        = r_ex.rs2;
    assign bus.ex_func3      = r_ex.func3;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_control_unit
// Purpose  : Directed scoreboard bench for pipelined_control_unit.
// Revision : 1.0
// ============================================================================
module tb_pipelined_control_unit;
    logic clk;
    logic rst;

    pipelined_control_unit_if #(.INSTR_W(32), .REG_AW(5)) bus ();

    pipelined_control_unit #(
        .INSTR_W    (32),
        .REG_AW     (5),
        .DIV_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] e;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Control word order: reg_write alu_src mem_read mem_write mem_to_reg
    // branch jump lui auipc illegal muldiv
    localparam logic [10:0] c_CTL_R     = 11'b100_0000_0000;
    localparam logic [10:0] c_CTL_LOAD  = 11'b111_0100_0000;
    localparam logic [10:0] c_CTL_AUIPC = 11'b110_0000_0100;
    localparam logic [10:0] c_CTL_ILL   = 11'b000_0000_0010;
    localparam logic [10:0] c_CTL_MD    = 11'b100_0000_0001;
    localparam logic [33:0] c_ZERO      = 34'd0;

    function automatic logic [33:0] mk(input logic st, input logic v, input logic [2:0] op,
                                       input logic [10:0] ctl, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3);
        return {st, v, op, ctl, rd, rs1, rs2, f3};
    endfunction

    task automatic cyc(input logic r, input logic [31:0] in, input logic v, input logic f,
                       input logic [33:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst             = r;
        bus.instr       = in;
        bus.instr_valid = v;
        bus.flush       = f;
        x.e  = e;
        x.nm = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents a stall decision and an ID/EX bundle every cycle.
    initial begin
        logic [33:0] act;
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {bus.stall, bus.ex_valid, bus.ex_alu_op, bus.ex_reg_write, bus.ex_alu_src,
                       bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_branch,
                       bus.ex_jump, bus.ex_lui, bus.ex_auipc, bus.ex_illegal, bus.ex_muldiv,
                       bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_func3};
                n_vec++;
                if (act !== x.e) begin
                    n_bad++;
                    $display("FAIL %s: got %09h expected %09h", x.nm, act, x.e);
                end
            end
        end
    end

    localparam logic [31:0] c_ADD3   = 32'h002081B3;
    localparam logic [31:0] c_LW5    = 32'h0000A283;
    localparam logic [31:0] c_ADD6   = 32'h00228333;
    localparam logic [31:0] c_LW0    = 32'h0000A003;
    localparam logic [31:0] c_ADD600 = 32'h00000333;
    localparam logic [31:0] c_ILL    = 32'h0000007F;
    localparam logic [31:0] c_AUIPC  = 32'h00001097;
    localparam logic [31:0] c_DIV    = 32'h0220C1B3;
    localparam logic [31:0] c_MUL    = 32'h022081B3;

    initial begin
        logic [33:0] e_add3, e_lw5, e_add6, e_lw0, e_add600, e_ill, e_auipc;
        int          guard;
        e_add3   = mk(1'b0, 1'b1, 3'b010, c_CTL_R,     5'd3, 5'd1, 5'd2, 3'd0);
        e_lw5    = mk(1'b0, 1'b1, 3'b000, c_CTL_LOAD,  5'd5, 5'd1, 5'd0, 3'd2);
        e_add6   = mk(1'b0, 1'b1, 3'b010, c_CTL_R,     5'd6, 5'd5, 5'd2, 3'd0);
        e_lw0    = mk(1'b0, 1'b1, 3'b000, c_CTL_LOAD,  5'd0, 5'd1, 5'd0, 3'd2);
        e_add600 = mk(1'b0, 1'b1, 3'b010, c_CTL_R,     5'd6, 5'd0, 5'd0, 3'd0);
        e_ill    = mk(1'b0, 1'b1, 3'b000, c_CTL_ILL,   5'd0, 5'd0, 5'd0, 3'd0);
        e_auipc  = mk(1'b0, 1'b1, 3'b000, c_CTL_AUIPC, 5'd1, 5'd0, 5'd0, 3'd1);

        rst             = 1'b1;
        bus.instr       = c_ADD3;
        bus.instr_valid = 1'b1;
        bus.flush       = 1'b0;

        cyc(1'b1, c_ADD3,   1'b1, 1'b0, c_ZERO,                "reset_hold");
        cyc(1'b0, c_ADD3,   1'b1, 1'b0, c_ZERO,                "reset_release");
        cyc(1'b0, c_LW5,    1'b1, 1'b0, e_add3,                "add_after_reset");
        cyc(1'b0, c_ADD6,   1'b1, 1'b0, e_lw5 | {1'b1, 33'd0}, "load_use_stall");
        cyc(1'b0, c_ADD6,   1'b1, 1'b0, c_ZERO,                "load_use_bubble");
        cyc(1'b0, c_LW0,    1'b1, 1'b0, e_add6,                "add_after_bubble");
        cyc(1'b0, c_ADD600, 1'b1, 1'b0, e_lw0,                 "lw_x0_no_stall");
        cyc(1'b0, c_LW5,    1'b1, 1'b0, e_add600,              "add_x0_latched");
        cyc(1'b0, c_ADD6,   1'b1, 1'b1, e_lw5,                 "flush_beats_hazard");
        cyc(1'b0, c_ADD6,   1'b1, 1'b0, c_ZERO,                "flush_bubble");
        cyc(1'b0, c_ILL,    1'b1, 1'b0, e_add6,                "add_after_flush");
        cyc(1'b0, c_AUIPC,  1'b1, 1'b0, e_ill,                 "illegal_opcode");
        cyc(1'b0, c_ILL,    1'b0, 1'b0, e_auipc,               "auipc");
        cyc(1'b0, c_ADD3,   1'b1, 1'b0, c_ZERO,                "invalid_no_illegal");
`ifdef RV32M_MULDIV_EN
        begin
            logic [33:0] e_div, e_mul;
            e_div = mk(1'b0, 1'b1, 3'b110, c_CTL_MD, 5'd3, 5'd1, 5'd2, 3'd4);
            e_mul = mk(1'b0, 1'b1, 3'b110, c_CTL_MD, 5'd3, 5'd1, 5'd2, 3'd0);
            cyc(1'b0, c_DIV,  1'b1, 1'b0, e_add3,                "add_before_div");
            cyc(1'b0, c_MUL,  1'b1, 1'b0, e_div | {1'b1, 33'd0}, "div_busy_1");
            cyc(1'b0, c_MUL,  1'b1, 1'b0, e_div | {1'b1, 33'd0}, "div_busy_2");
            cyc(1'b0, c_MUL,  1'b1, 1'b0, e_div | {1'b1, 33'd0}, "div_busy_3");
            cyc(1'b0, c_MUL,  1'b1, 1'b0, e_div,                 "div_done");
            cyc(1'b0, c_DIV,  1'b1, 1'b0, e_mul,                 "mul_no_stall");
            cyc(1'b0, c_ADD3, 1'b1, 1'b0, e_div | {1'b1, 33'd0}, "div2_busy_1");
            cyc(1'b0, c_ADD3, 1'b1, 1'b1, e_div,                 "div2_flush");
            cyc(1'b0, c_ADD3, 1'b1, 1'b0, c_ZERO,                "div2_flush_bubble");
            cyc(1'b0, c_ADD3, 1'b0, 1'b0, e_add3,                "add_after_div_flush");
        end
`else
        begin
            logic [33:0] e_divr, e_mulr;
            e_divr = mk(1'b0, 1'b1, 3'b010, c_CTL_R, 5'd3, 5'd1, 5'd2, 3'd4);
            e_mulr = mk(1'b0, 1'b1, 3'b010, c_CTL_R, 5'd3, 5'd1, 5'd2, 3'd0);
            cyc(1'b0, c_DIV,  1'b1, 1'b0, e_add3, "add_before_div");
            cyc(1'b0, c_MUL,  1'b1, 1'b0, e_divr, "div_as_plain_r");
            cyc(1'b0, c_ADD3, 1'b0, 1'b0, e_mulr, "mul_as_plain_r");
        end
`endif
        cyc(1'b0, c_LW5,  1'b1, 1'b0, c_ZERO,                "bubble_before_reset");
        cyc(1'b0, c_ADD6, 1'b1, 1'b0, e_lw5 | {1'b1, 33'd0}, "stall_before_reset");
        cyc(1'b1, c_ADD6, 1'b1, 1'b0, c_ZERO,                "reset_mid_stall");
        cyc(1'b0, c_ADD6, 1'b1, 1'b0, c_ZERO,                "reset_mid_stall_release");
        cyc(1'b0, c_ADD6, 1'b0, 1'b0, e_add6,                "add_after_mid_reset");

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
